// File: rtl/wb_pkg.sv
// Shared types and default sizes for the register-file writeback arbiter.
package wb_pkg;

    localparam int unsigned WB_N_SRC = 4;
    localparam int unsigned WB_ADDR  = 5;
    localparam int unsigned WB_WIDTH = 32;
    localparam int unsigned WB_TAG_W = 4;

    // One execution-unit result heading for the register file.
    typedef struct packed {
        logic [WB_ADDR-1:0]  rd;
        logic [WB_WIDTH-1:0] data;
        logic [WB_TAG_W-1:0] tag;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from the pointer,
// pointer advances past the winner on every grant and holds otherwise.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic          found;
    int unsigned   idx;

    // First requester at or after the pointer, wrapping modulo N.
    always_comb begin
        gnt   = '0;
        gidx  = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr) + k) % N;
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                gidx     = PW'(idx);
                found    = 1'b1;
            end
        end
    end

    // Pointer moves to the source after the winner; holds when nothing is granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + PW'(1);
        end
    end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Serialises execution-unit results onto the single register-file write port
// with round-robin fairness and a one-cycle registered output stage.
// Optional build macro WB_STATS_EN adds stat_writes / stat_conflicts counters.
module rf_writeback_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned N_SRC = WB_N_SRC,
    parameter int unsigned ADDR  = WB_ADDR,
    parameter int unsigned WIDTH = WB_WIDTH,
    parameter int unsigned TAG_W = WB_TAG_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [N_SRC-1:0]       src_valid,
    output logic [N_SRC-1:0]       src_ready,
    input  logic [N_SRC*ADDR-1:0]  src_rd,
    input  logic [N_SRC*WIDTH-1:0] src_data,
    input  logic [N_SRC*TAG_W-1:0] src_tag,
    output logic                   rf_we,
    output logic [ADDR-1:0]        rf_waddr,
    output logic [WIDTH-1:0]       rf_wdata,
    output logic                   cpl_valid,
    output logic [TAG_W-1:0]       cpl_tag
`ifdef WB_STATS_EN
    ,
    output logic [31:0]            stat_writes,
    output logic [31:0]            stat_conflicts
`endif
);

    wb_req_t          req [N_SRC];
    wb_req_t          sel;
    logic [N_SRC-1:0] gnt;
    logic             any_gnt;
    logic             arb_en;

    // No grants during flush or reset so nothing is handshaken and then lost.
    assign arb_en = !flush && !rst;

    rr_arbiter #(.N(N_SRC)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (src_valid),
        .en  (arb_en),
        .gnt (gnt)
    );

    assign src_ready = gnt;
    assign any_gnt   = |gnt;

    // Unpack the flat source buses into per-source requests.
    always_comb begin
        for (int unsigned i = 0; i < N_SRC; i++) begin
            req[i].rd   = WB_ADDR'(src_rd[i*ADDR +: ADDR]);
            req[i].data = WB_WIDTH'(src_data[i*WIDTH +: WIDTH]);
            req[i].tag  = WB_TAG_W'(src_tag[i*TAG_W +: TAG_W]);
        end
    end

    // Pick the granted request; grant is one-hot so a priority loop is exact.
    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (gnt[i]) begin
                sel = req[i];
            end
        end
    end

    // Output stage: pulse strobes per accepted result, hold payload when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            cpl_valid <= 1'b0;
            cpl_tag   <= '0;
        end else begin
            rf_we     <= any_gnt && (sel.rd != '0);
            cpl_valid <= any_gnt;
            if (any_gnt) begin
                rf_waddr <= ADDR'(sel.rd);
                rf_wdata <= WIDTH'(sel.data);
                cpl_tag  <= TAG_W'(sel.tag);
            end
        end
    end

`ifdef WB_STATS_EN
    logic multi_valid;

    // Two or more bits set iff clearing the lowest set bit leaves something.
    assign multi_valid = |(src_valid & (src_valid - N_SRC'(1)));

    // Saturating activity counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_writes    <= '0;
            stat_conflicts <= '0;
        end else begin
            if (rf_we && (stat_writes != '1)) begin
                stat_writes <= stat_writes + 32'd1;
            end
            if (multi_valid && !flush && (stat_conflicts != '1)) begin
                stat_conflicts <= stat_conflicts + 32'd1;
            end
        end
    end
`endif

endmodule
